// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared pipeline definitions for the hazard tracker: defaults, operand-select encoding
// and the per-stage bookkeeping entry.
package pipe_hazard_tracker_pkg;

    localparam int unsigned REG_W_DEF      = 4;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned LOAD_READY_DEF = 2;

    // Stage entries carry a fixed-width dest so the struct stays unparameterised;
    // REG_W must not exceed this.
    localparam int unsigned REG_W_MAX = 8;

    // Operand select value meaning "take the register file"
    localparam int unsigned SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_read;
        logic [REG_W_MAX-1:0] dest;
    } stage_entry_t;

endpackage

// File: rtl/hazard_stage_cmp.sv
// Compares one in-flight stage entry against the ID source registers.
module hazard_stage_cmp
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  stage_entry_t     entry_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             src1_valid_i,
    input  logic             two_src_i,
    output logic             match1_o,
    output logic             match2_o,
    output logic             load_match_o
);

    logic writes;

    always_comb begin
        writes       = entry_i.valid & entry_i.wb_en;
        match1_o     = writes & src1_valid_i & (entry_i.dest == REG_W_MAX'(src1_i));
        match2_o     = writes & two_src_i & (entry_i.dest == REG_W_MAX'(src2_i));
        load_match_o = entry_i.mem_read & (match1_o | match2_o);
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks write-back destinations of instructions past ID, raising a stall request on
// unresolved RAW hazards and registering the EX operand forwarding selects.
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int unsigned REG_W      = REG_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_READY = LOAD_READY_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forwardEn,
    input  logic                     issueValid,
    input  logic                     issueWbEn,
    input  logic                     issueMemRead,
    input  logic [REG_W-1:0]         issueDest,
    input  logic [REG_W-1:0]         src1,
    input  logic [REG_W-1:0]         src2,
    input  logic                     src1Valid,
    input  logic                     twoSrc,
    input  logic                     flush,
    output logic                     hazard,
    output logic [$clog2(DEPTH)-1:0] selSrc1,
    output logic [$clog2(DEPTH)-1:0] selSrc2,
    output logic [CNT_W-1:0]         stallCount
);

    localparam int unsigned SEL_W = $clog2(DEPTH);

    stage_entry_t     stage_q [DEPTH];
    stage_entry_t     stage_d [DEPTH];
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic [DEPTH-1:0] load_match;
    logic [SEL_W-1:0] fwd1;
    logic [SEL_W-1:0] fwd2;
    logic [SEL_W-1:0] sel1_q, sel1_d;
    logic [SEL_W-1:0] sel2_q, sel2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_hazard;
    logic             issue_ok;

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_stage_cmp #(
            .REG_W (REG_W)
        ) u_cmp (
            .entry_i      (stage_q[k]),
            .src1_i       (src1),
            .src2_i       (src2),
            .src1_valid_i (src1Valid),
            .two_src_i    (twoSrc),
            .match1_o     (match1[k]),
            .match2_o     (match2[k]),
            .load_match_o (load_match[k])
        );
    end

    // The WB stage (DEPTH-1) writes the register file this cycle, so it never
    // causes a stall or a forward.
    always_comb begin
        raw_hazard = 1'b0;
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
            if (forwardEn) begin
                if (k < int'(LOAD_READY) - 1 && load_match[k]) begin
                    raw_hazard = 1'b1;
                end
            end else if (match1[k] || match2[k]) begin
                raw_hazard = 1'b1;
            end
        end
        hazard   = raw_hazard & issueValid & ~flush;
        issue_ok = issueValid & ~hazard & ~flush;
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd1 = SEL_W'(SEL_RF);
        fwd2 = SEL_W'(SEL_RF);
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            if (match1[k]) begin
                fwd1 = SEL_W'(k + 1);
            end
            if (match2[k]) begin
                fwd2 = SEL_W'(k + 1);
            end
        end
    end

    always_comb begin
        stage_d[0] = '0;
        if (issue_ok) begin
            stage_d[0].valid    = 1'b1;
            stage_d[0].wb_en    = issueWbEn;
            stage_d[0].mem_read = issueMemRead;
            stage_d[0].dest     = REG_W_MAX'(issueDest);
        end
        for (int k = 1; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
        end

        sel1_d = SEL_W'(SEL_RF);
        sel2_d = SEL_W'(SEL_RF);
        if (issue_ok && forwardEn) begin
            sel1_d = fwd1;
            sel2_d = fwd2;
        end

        cnt_d = cnt_q;
        if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= '0;
            end
            sel1_q <= SEL_W'(SEL_RF);
            sel2_q <= SEL_W'(SEL_RF);
            cnt_q  <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= stage_d[k];
            end
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign selSrc1    = sel1_q;
    assign selSrc2    = sel2_q;
    assign stallCount = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: three configurations share one stimulus stream and are
// each checked against an issue-history model plus directed scenario expectations.
module tb_pipe_hazard_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, forwardEn, issueValid, issueWbEn, issueMemRead, flush, src1Valid, twoSrc;
    logic [3:0] issueDest, src1, src2;

    logic        haz [3];
    logic [1:0]  s1_0, s2_0, s1_1, s2_1, c1;
    logic [2:0]  s1_2, s2_2;
    logic [15:0] c0, c2;
    logic [3:0]  sel1_a [3];
    logic [3:0]  sel2_a [3];
    logic [15:0] cnt_a  [3];

    assign sel1_a[0] = {2'b00, s1_0};
    assign sel1_a[1] = {2'b00, s1_1};
    assign sel1_a[2] = {1'b0, s1_2};
    assign sel2_a[0] = {2'b00, s2_0};
    assign sel2_a[1] = {2'b00, s2_1};
    assign sel2_a[2] = {1'b0, s2_2};
    assign cnt_a[0]  = c0;
    assign cnt_a[1]  = {14'd0, c1};
    assign cnt_a[2]  = c2;

    pipe_hazard_tracker #(.REG_W(4), .DEPTH(3), .LOAD_READY(2), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .issueValid(issueValid),
        .issueWbEn(issueWbEn), .issueMemRead(issueMemRead), .issueDest(issueDest),
        .src1(src1), .src2(src2), .src1Valid(src1Valid), .twoSrc(twoSrc), .flush(flush),
        .hazard(haz[0]), .selSrc1(s1_0), .selSrc2(s2_0), .stallCount(c0)
    );

    pipe_hazard_tracker #(.REG_W(4), .DEPTH(3), .LOAD_READY(2), .CNT_W(2)) u_d1 (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .issueValid(issueValid),
        .issueWbEn(issueWbEn), .issueMemRead(issueMemRead), .issueDest(issueDest),
        .src1(src1), .src2(src2), .src1Valid(src1Valid), .twoSrc(twoSrc), .flush(flush),
        .hazard(haz[1]), .selSrc1(s1_1), .selSrc2(s2_1), .stallCount(c1)
    );

    pipe_hazard_tracker #(.REG_W(4), .DEPTH(5), .LOAD_READY(3), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .issueValid(issueValid),
        .issueWbEn(issueWbEn), .issueMemRead(issueMemRead), .issueDest(issueDest),
        .src1(src1), .src2(src2), .src1Valid(src1Valid), .twoSrc(twoSrc), .flush(flush),
        .hazard(haz[2]), .selSrc1(s1_2), .selSrc2(s2_2), .stallCount(c2)
    );

    int P_DEPTH [3] = '{3, 3, 5};
    int P_LR    [3] = '{2, 2, 3};
    int P_MAX   [3] = '{65535, 3, 65535};

    // Model: record of what each configuration accepted into EX on every cycle.
    // The instruction accepted on cycle c sits k stages past ID during cycle c+1+k.
    int       cyc = 0;
    int       vfrom [3];
    bit       hv  [3][16];
    bit       hwb [3][16];
    bit       hmr [3][16];
    bit [3:0] hd  [3][16];
    int       e_sel1 [3];
    int       e_sel2 [3];
    int       e_cnt  [3];

    int n_checks = 0;
    int n_errs   = 0;

    function automatic bit hit(int i, int k, int which, bit load_only);
        int c;
        int s;
        c = cyc - 1 - k;
        if (c < vfrom[i]) return 1'b0;
        s = c % 16;
        if (!hv[i][s] || !hwb[i][s] || (load_only && !hmr[i][s])) return 1'b0;
        if (which != 2 && src1Valid && hd[i][s] == src1) return 1'b1;
        if (which != 1 && twoSrc && hd[i][s] == src2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_haz(int i);
        if (!issueValid || flush) return 1'b0;
        for (int k = 0; k <= P_DEPTH[i] - 2; k++) begin
            if (forwardEn) begin
                if (k < P_LR[i] - 1 && hit(i, k, 0, 1'b1)) return 1'b1;
            end else if (hit(i, k, 0, 1'b0)) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int exp_fwd(int i, int which);
        for (int k = 0; k <= P_DEPTH[i] - 2; k++) begin
            if (hit(i, k, which, 1'b0)) return k + 1;
        end
        return 0;
    endfunction

    task automatic tick();
        bit h;
        bit acc;
        int s;
        for (int i = 0; i < 3; i++) begin
            h = exp_haz(i);
            if (rst) begin
                vfrom[i]  = cyc + 1;
                e_sel1[i] = 0;
                e_sel2[i] = 0;
                e_cnt[i]  = 0;
            end else begin
                acc       = issueValid && !h && !flush;
                e_sel1[i] = (acc && forwardEn) ? exp_fwd(i, 1) : 0;
                e_sel2[i] = (acc && forwardEn) ? exp_fwd(i, 2) : 0;
                if (h && e_cnt[i] < P_MAX[i]) e_cnt[i]++;
                s         = cyc % 16;
                hv[i][s]  = acc;
                hwb[i][s] = issueWbEn;
                hmr[i][s] = issueMemRead;
                hd[i][s]  = issueDest;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_instr(input bit v, input bit wb, input bit mr, input int dest,
                             input int s1, input bit s1v, input int s2, input bit ts);
        issueValid   = v;
        issueWbEn    = wb;
        issueMemRead = mr;
        issueDest    = 4'(dest);
        src1         = 4'(s1);
        src1Valid    = s1v;
        src2         = 4'(s2);
        twoSrc       = ts;
    endtask

    task automatic idle();
        set_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        forwardEn = 1'b0;
        flush     = 1'b0;
        set_instr(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;
        set_instr(1'b1, 1'b0, 1'b0, 7, 3, 1'b1, 3, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (haz[i] !== 1'b0) begin
                n_errs++; $display("FAIL reset_hazard[%0d]: got %b want 0", i, haz[i]);
            end
            n_checks++;
            if (sel1_a[i] !== 4'd0) begin
                n_errs++; $display("FAIL reset_sel1[%0d]: got %0d want 0", i, sel1_a[i]);
            end
            n_checks++;
            if (sel2_a[i] !== 4'd0) begin
                n_errs++; $display("FAIL reset_sel2[%0d]: got %0d want 0", i, sel2_a[i]);
            end
            n_checks++;
            if (cnt_a[i] !== 16'd0) begin
                n_errs++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, cnt_a[i]);
            end
        end
    endtask

    task automatic test_stall_nofwd();
        do_reset();
        forwardEn = 1'b0;
        set_instr(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0);
        #1; tick();
        set_instr(1'b1, 1'b0, 1'b0, 7, 3, 1'b1, 0, 1'b0);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (haz[0] !== (c < 2)) begin
                n_errs++; $display("FAIL nofwd_hazard_c%0d: got %b want %b", c, haz[0], c < 2);
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (c0 !== 16'd2) begin
            n_errs++; $display("FAIL nofwd_stallcount: got %0d want 2", c0);
        end
    endtask

    task automatic test_forward();
        for (int gap = 0; gap < 2; gap++) begin
            do_reset();
            forwardEn = 1'b1;
            set_instr(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0);
            #1; tick();
            if (gap == 1) begin
                set_instr(1'b1, 1'b1, 1'b0, 9, 1, 1'b1, 2, 1'b1);
                #1; tick();
            end
            set_instr(1'b1, 1'b0, 1'b0, 7, 3, 1'b1, 0, 1'b0);
            #1;
            n_checks++;
            if (haz[0] !== 1'b0) begin
                n_errs++; $display("FAIL fwd_hazard_gap%0d: got %b want 0", gap, haz[0]);
            end
            tick();
            idle();
            #1;
            n_checks++;
            if (sel1_a[0] !== 4'(gap + 1)) begin
                n_errs++;
                $display("FAIL fwd_sel1_gap%0d: got %0d want %0d", gap, sel1_a[0], gap + 1);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        forwardEn = 1'b1;
        set_instr(1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 0, 1'b0);
        #1; tick();
        set_instr(1'b1, 1'b0, 1'b0, 8, 0, 1'b0, 5, 1'b1);
        #1;
        n_checks++;
        if (haz[0] !== 1'b1 || haz[2] !== 1'b1) begin
            n_errs++; $display("FAIL load_c1: got %b/%b want 1/1", haz[0], haz[2]);
        end
        tick();
        n_checks++;
        if (haz[0] !== 1'b0 || haz[2] !== 1'b1 || sel2_a[0] !== 4'd0) begin
            n_errs++;
            $display("FAIL load_c2: got haz %b/%b sel2 %0d want 0/1 sel2 0",
                     haz[0], haz[2], sel2_a[0]);
        end
        tick();
        n_checks++;
        if (sel2_a[0] !== 4'd2 || haz[2] !== 1'b0) begin
            n_errs++;
            $display("FAIL load_c3: got sel2 %0d haz2 %b want sel2 2 haz2 0", sel2_a[0], haz[2]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (sel2_a[2] !== 4'd3) begin
            n_errs++; $display("FAIL load_deep_sel2: got %0d want 3", sel2_a[2]);
        end
        n_checks++;
        if (c0 !== 16'd1 || c2 !== 16'd2) begin
            n_errs++; $display("FAIL load_counts: got %0d/%0d want 1/2", c0, c2);
        end
    endtask

    task automatic test_flush();
        do_reset();
        forwardEn = 1'b0;
        set_instr(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0);
        #1; tick();
        set_instr(1'b1, 1'b1, 1'b0, 6, 3, 1'b1, 0, 1'b0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (haz[0] !== 1'b0) begin
            n_errs++; $display("FAIL flush_hazard: got %b want 0", haz[0]);
        end
        tick();
        flush = 1'b0;
        set_instr(1'b1, 1'b0, 1'b0, 9, 6, 1'b1, 0, 1'b0);
        #1;
        n_checks++;
        if (haz[0] !== 1'b0) begin
            n_errs++; $display("FAIL flush_bubble: got hazard %b want 0", haz[0]);
        end
        n_checks++;
        if (c0 !== 16'd0) begin
            n_errs++; $display("FAIL flush_stallcount: got %0d want 0", c0);
        end
        tick();
        idle();
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        forwardEn = 1'b0;
        set_instr(1'b1, 1'b1, 1'b0, 3, 3, 1'b1, 0, 1'b0);
        #1;
        repeat (8) tick();
        n_checks++;
        if (c1 !== 2'd3 || c0 !== 16'd5) begin
            n_errs++; $display("FAIL sat_count: got %0d/%0d want 3/5", c1, c0);
        end
        n_checks++;
        if (haz[0] !== 1'b1) begin
            n_errs++; $display("FAIL sat_midstall: got hazard %b want 1", haz[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (haz[i] !== 1'b0 || sel1_a[i] !== 4'd0 || sel2_a[i] !== 4'd0 ||
                cnt_a[i] !== 16'd0) begin
                n_errs++;
                $display("FAIL midstall_reset[%0d]: got haz %b sel %0d/%0d cnt %0d want zeros",
                         i, haz[i], sel1_a[i], sel2_a[i], cnt_a[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 0) forwardEn = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) < 3, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 6) != 0,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            #1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (haz[i] !== exp_haz(i)) begin
                    n_errs++;
                    $display("FAIL rnd_hazard[%0d] cyc %0d: got %b want %b",
                             i, cyc, haz[i], exp_haz(i));
                end
                n_checks++;
                if (sel1_a[i] !== 4'(e_sel1[i]) || sel2_a[i] !== 4'(e_sel2[i])) begin
                    n_errs++;
                    $display("FAIL rnd_sel[%0d] cyc %0d: got %0d/%0d want %0d/%0d",
                             i, cyc, sel1_a[i], sel2_a[i], e_sel1[i], e_sel2[i]);
                end
                n_checks++;
                if (cnt_a[i] !== 16'(e_cnt[i])) begin
                    n_errs++;
                    $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d",
                             i, cyc, cnt_a[i], e_cnt[i]);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        forwardEn = 1'b0;
        flush     = 1'b0;
        idle();
        #1;
        test_reset();
        test_stall_nofwd();
        test_forward();
        test_load_use();
        test_flush();
        test_saturate_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
